// File: rtl/wb_store_queue_if.sv
// Bundle of write-back enqueue, memory drain and load-probe signals for the store queue.
// The master side drives stores, acks and probes; the slave side is the queue itself.
interface wb_store_queue_if #(
    parameter int unsigned PTR_W = 2
);
    logic             enq_v;
    logic [14:0]      enq_pa;
    logic [31:0]      enq_data;
    logic [1:0]       enq_size;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             mem_req;
    logic [14:0]      mem_pa;
    logic [31:0]      mem_data;
    logic [1:0]       mem_size;
    logic             mem_ack;
    logic             ld_v;
    logic [14:0]      ld_pa;
    logic             ld_conflict;

    modport master (
        output enq_v, enq_pa, enq_data, enq_size, mem_ack, ld_v, ld_pa,
        input  full, empty, count, overflow, mem_req, mem_pa, mem_data, mem_size, ld_conflict
    );

    modport slave (
        input  enq_v, enq_pa, enq_data, enq_size, mem_ack, ld_v, ld_pa,
        output full, empty, count, overflow, mem_req, mem_pa, mem_data, mem_size, ld_conflict
    );
endinterface

// File: rtl/wb_store_queue.sv
// In-order store queue: buffers write-back stores and drains them one at a time over req/ack,
// flagging loads whose word address matches any still-pending store.
module wb_store_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input logic             clk,
    input logic             rst,
    wb_store_queue_if.slave sq
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    logic [14:0]      pa_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [1:0]       size_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PTR_W-1:0] head_q, tail_q, head_next;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q;

    state_e           state_q, state_d;
    logic [14:0]      mem_pa_q, mem_pa_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic [1:0]       mem_size_q, mem_size_d;

    logic             full, empty, enq_ok, deq, ld_hit;

    // full/empty come from registered count, so a same-cycle ack never frees a slot for enq
    assign full      = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_ok    = sq.enq_v & ~full;
    assign deq       = (state_q == StReq) & sq.mem_ack;
    assign head_next = PTR_W'(head_q + 1'b1);

    always_comb begin
        count_d = count_q;
        if (enq_ok && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Entry payload carries no reset; valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            pa_q[tail_q]   <= sq.enq_pa;
            data_q[tail_q] <= sq.enq_data;
            size_q[tail_q] <= sq.enq_size;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq_ok) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= PTR_W'(tail_q + 1'b1);
            end
            // head and tail never coincide when enq and deq both fire (empty or full)
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_next;
            end
            if (sq.enq_v && full) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_pa_d   = mem_pa_q;
        mem_data_d = mem_data_q;
        mem_size_d = mem_size_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d    = StReq;
                    mem_pa_d   = pa_q[head_q];
                    mem_data_d = data_q[head_q];
                    mem_size_d = size_q[head_q];
                end
            end
            StReq: begin
                if (sq.mem_ack) begin
                    if (count_q > (PTR_W + 1)'(1)) begin
                        // Back-to-back: present the next store without an idle bubble
                        state_d    = StReq;
                        mem_pa_d   = pa_q[head_next];
                        mem_data_d = data_q[head_next];
                        mem_size_d = size_q[head_next];
                    end else begin
                        state_d    = StIdle;
                        mem_pa_d   = '0;
                        mem_data_d = '0;
                        mem_size_d = '0;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                mem_pa_d   = '0;
                mem_data_d = '0;
                mem_size_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mem_pa_q   <= '0;
            mem_data_q <= '0;
            mem_size_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_pa_q   <= mem_pa_d;
            mem_data_q <= mem_data_d;
            mem_size_q <= mem_size_d;
        end
    end

    // Only registered entries participate, so a store enqueued this cycle cannot hit.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (pa_q[i][14:2] == sq.ld_pa[14:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign sq.full        = full;
    assign sq.empty       = empty;
    assign sq.count       = count_q;
    assign sq.overflow    = overflow_q;
    assign sq.mem_req     = (state_q == StReq);
    assign sq.mem_pa      = mem_pa_q;
    assign sq.mem_data    = mem_data_q;
    assign sq.mem_size    = mem_size_q;
    assign sq.ld_conflict = sq.ld_v & ld_hit;

endmodule
